// File: rtl/ibus_line_buffer_pkg.sv
// Shared bus types and constants for the fetch-side (ibus) and
// cache-side (cbus) interfaces of the instruction line buffer.
package ibus_line_buffer_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // len carries the number of beats in the burst.
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // Clears the byte offset inside a line of (1 << ofs_bits) bytes.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int ofs_bits);
    return addr & ~((32'd1 << ofs_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/ibus_line_buffer_line_ram.sv
// Word storage for the buffered line: one write port fed by refill
// beats, one combinational read port selecting the word to return.
module ibus_line_buffer_line_ram #(
  parameter int WORDS    = 4,
  parameter int IDX_BITS = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_BITS-1:0] widx,
  input  logic [31:0]         wdata,
  input  logic [IDX_BITS-1:0] ridx,
  output logic [31:0]         rdata
);

  logic [31:0] mem [WORDS];

  // Capture one refill beat per enabled cycle.
  // NOTE: the array has no reset; line_valid guards every read, so stale
  // contents are never observed and the storage stays plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/ibus_line_buffer.sv
// Single-line instruction buffer: answers fetch hits from the held line
// and refills the whole line with one cbus burst on a miss.
module ibus_line_buffer
  import ibus_line_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  input  logic       invalidate
);

  localparam int OFS_BITS = $clog2(LINE_WORDS) + 2;
  localparam int IDX_BITS = $clog2(LINE_WORDS);
  localparam int TAG_BITS = 32 - OFS_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t              state;
  logic                line_valid;
  logic                inv_seen;     // invalidate seen during the current refill
  logic [TAG_BITS-1:0] tag;
  logic [31:0]         req_addr;
  logic [IDX_BITS-1:0] cnt;
  logic                creq_valid;
  logic                data_ok;
  logic [31:0]         data;

  logic                hit;
  logic                beat;
  logic                done;
  logic [IDX_BITS-1:0] req_idx;
  logic [IDX_BITS-1:0] ridx;
  logic [31:0]         rdata;
  logic                unused_low_bits;

  assign hit     = line_valid && (ireq.addr[31:OFS_BITS] == tag);
  assign beat    = (state == REFILL) && cresp.ready;
  assign done    = beat && cresp.last;
  assign req_idx = req_addr[OFS_BITS-1:2];
  // In IDLE the word comes straight from the incoming address so a hit
  // can be registered in the acceptance cycle.
  assign ridx    = (state == IDLE) ? ireq.addr[OFS_BITS-1:2] : req_idx;

  // Word-aligned fetches only: the byte lane bits carry no information.
  assign unused_low_bits = ^{ireq.addr[1:0], req_addr[1:0]};

  ibus_line_buffer_line_ram #(
    .WORDS   (LINE_WORDS),
    .IDX_BITS(IDX_BITS)
  ) u_line_ram (
    .clk  (clk),
    .we   (beat),
    .widx (cnt),
    .wdata(cresp.data),
    .ridx (ridx),
    .rdata(rdata)
  );

  // Request FSM with registered cbus valid and fetch response.
  // NOTE: every state update uses <= so all branches see pre-edge values;
  // a later <= to the same signal in this block overrides an earlier one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      line_valid <= 1'b0;
      inv_seen   <= 1'b0;
      tag        <= '0;
      req_addr   <= '0;
      cnt        <= '0;
      creq_valid <= 1'b0;
      data_ok    <= 1'b0;
      data       <= '0;
    end else begin
      data_ok <= 1'b0;
      if (invalidate) line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ireq.valid) begin
            req_addr <= ireq.addr;
            if (hit) begin
              data    <= rdata;
              data_ok <= 1'b1;
              state   <= RESP;
            end else begin
              // The old line is overwritten beat by beat, so it stops being valid now.
              line_valid <= 1'b0;
              inv_seen   <= 1'b0;
              cnt        <= '0;
              creq_valid <= 1'b1;
              state      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (invalidate) inv_seen <= 1'b1;
          if (beat) cnt <= cnt + IDX_BITS'(1);
          if (done) begin
            tag        <= req_addr[31:OFS_BITS];
            line_valid <= !(inv_seen || invalidate);
            data       <= (req_idx == cnt) ? cresp.data : rdata;
            data_ok    <= 1'b1;
            creq_valid <= 1'b0;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Burst request fields, driven only while a refill is outstanding.
  // NOTE: default assignment first keeps this block free of latches.
  always_comb begin
    creq = '0;
    if (creq_valid) begin
      creq.valid    = 1'b1;
      creq.is_write = 1'b0;
      creq.size     = MSIZE4;
      creq.addr     = line_base(req_addr, OFS_BITS);
      creq.strobe   = '0;
      creq.data     = '0;
      creq.len      = 8'(LINE_WORDS);
    end
  end

  // addr_ok is combinational so the request is accepted in its own cycle.
  assign iresp.addr_ok = resetn && (state == IDLE) && ireq.valid;
  assign iresp.data_ok = data_ok;
  assign iresp.data    = data;

  // The memory side must flag last only on the final beat of the line.
  last_on_final_beat: assert property (
    @(posedge clk) disable iff (!resetn)
    (beat && cresp.last) |-> (cnt == IDX_BITS'(LINE_WORDS - 1))
  );

endmodule

// File: tb/tb_ibus_line_buffer.sv
// Bench for ibus_line_buffer: directed vector table, hand-written
// corner sequences (redirect, reset mid-burst) and randomized fetches
// checked against a line-level reference model.
module tb_ibus_line_buffer;
  import ibus_line_buffer_pkg::*;

  localparam int LW         = 4;
  localparam int LINE_BYTES = LW * 4;

  logic       clk;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       invalidate;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which line is held and what it contains.
  bit          model_valid;
  logic [31:0] model_base;
  logic [31:0] model_line [LW];
  logic [31:0] beat_data  [LW];

  ibus_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ireq      (ireq),
    .iresp     (iresp),
    .creq      (creq),
    .cresp     (cresp),
    .invalidate(invalidate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    logic [31:0] b0, b1, b2, b3;
    int          ready_mode;  // 0 always ready, 1 alternating, 2 random
    bit          inv_last;
    bit          pre_inv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic [31:0] addr, input bit exp_hit,
                              input logic [31:0] b0, b1, b2, b3,
                              input int rm, input bit invl, input bit prei,
                              input logic [31:0] exp_data);
    vec_t v;
    v.addr = addr; v.exp_hit = exp_hit;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.ready_mode = rm; v.inv_last = invl; v.pre_inv = prei;
    v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a - (a % LINE_BYTES);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a % LINE_BYTES) / 4);
  endfunction

  // Drive one fetch and any refill it needs; check handshake and data.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_data,
                       input int ready_mode, input bit inv_last, input bit pre_inv,
                       input logic [31:0] redir, input string name);
    int   beat;
    int   cyc;
    logic rdy;
    if (pre_inv) begin
      @(negedge clk); invalidate = 1'b1;
      @(negedge clk); invalidate = 1'b0;
    end
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = addr;
    #1 check({name, " addr_ok"}, 32'(iresp.addr_ok), 32'd1);
    @(negedge clk);
    ireq.valid = 1'b0;
    #1;
    if (exp_hit) begin
      check({name, " hit no creq"}, 32'(creq.valid), 32'd0);
    end else begin
      check({name, " creq.valid"}, 32'(creq.valid), 32'd1);
      check({name, " creq.addr"}, creq.addr, base_of(addr));
      check({name, " creq.len"}, 32'(creq.len), 32'(LW));
      check({name, " creq.size"}, 32'(creq.size), 32'(MSIZE4));
      beat = 0;
      cyc  = 0;
      while (beat < LW && cyc < 200) begin
        if (redir != 32'd0) begin
          ireq.valid = 1'b1;
          ireq.addr  = redir;
        end
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2) == 0;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        cresp.ready = rdy;
        cresp.data  = rdy ? beat_data[beat] : 32'hdead_beef;
        cresp.last  = rdy && (beat == LW - 1);
        invalidate  = inv_last && cresp.last;
        #1 check({name, " creq held"}, creq.addr, base_of(addr));
        @(posedge clk);
        if (rdy) beat++;
        cyc++;
        @(negedge clk);
      end
      cresp      = '0;
      invalidate = 1'b0;
      ireq.valid = 1'b0;
      check({name, " beats accepted"}, 32'(beat), 32'(LW));
      #1 check({name, " creq dropped"}, 32'(creq.valid), 32'd0);
    end
    check({name, " data_ok"}, 32'(iresp.data_ok), 32'd1);
    check({name, " data"}, iresp.data, exp_data);
    @(negedge clk);
    #1 check({name, " data_ok one cycle"}, 32'(iresp.data_ok), 32'd0);
  endtask

  task automatic model_after(input logic [31:0] addr, input bit was_hit, input bit inv_last);
    if (!was_hit) begin
      if (inv_last) model_valid = 1'b0;
      else begin
        model_valid = 1'b1;
        model_base  = base_of(addr);
        for (int w = 0; w < LW; w++) model_line[w] = beat_data[w];
      end
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] exp;
    bit          hit;
    bit          pre;
    bit          invl;
    int          rm;

    vecs[0]  = mk(32'hbfc0_0000, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 32'h11);
    vecs[1]  = mk(32'hbfc0_0008, 1, 0, 0, 0, 0, 0, 0, 0, 32'h33);
    vecs[2]  = mk(32'hbfc0_001c, 0, 32'ha0, 32'ha1, 32'ha2, 32'ha3, 1, 0, 0, 32'ha3);
    vecs[3]  = mk(32'hbfc0_0010, 1, 0, 0, 0, 0, 0, 0, 0, 32'ha0);
    vecs[4]  = mk(32'hbfc0_0014, 1, 0, 0, 0, 0, 0, 0, 0, 32'ha1);
    vecs[5]  = mk(32'hbfc0_0000, 0, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 32'h11);
    vecs[6]  = mk(32'hbfc0_0014, 0, 32'hb0, 32'hb1, 32'hb2, 32'hb3, 0, 0, 0, 32'hb1);
    vecs[7]  = mk(32'hbfc0_0014, 1, 0, 0, 0, 0, 0, 0, 0, 32'hb1);
    vecs[8]  = mk(32'hbfc0_0014, 0, 32'hc0, 32'hc1, 32'hc2, 32'hc3, 0, 0, 1, 32'hc1);
    vecs[9]  = mk(32'hbfc0_0020, 0, 32'hd0, 32'hd1, 32'hd2, 32'hd3, 0, 1, 0, 32'hd0);
    vecs[10] = mk(32'hbfc0_0020, 0, 32'he0, 32'he1, 32'he2, 32'he3, 0, 0, 0, 32'he0);
    vecs[11] = mk(32'hbfc0_0028, 1, 0, 0, 0, 0, 0, 0, 0, 32'he2);

    // Reset with a request pending: all outputs must stay low.
    resetn     = 1'b0;
    ireq.valid = 1'b1;
    ireq.addr  = 32'hbfc0_0000;
    cresp      = '0;
    invalidate = 1'b0;
    model_valid = 1'b0;
    model_base  = '0;
    #12;
    check("reset addr_ok", 32'(iresp.addr_ok), 32'd0);
    check("reset data_ok", 32'(iresp.data_ok), 32'd0);
    check("reset data", iresp.data, 32'd0);
    check("reset creq.valid", 32'(creq.valid), 32'd0);
    ireq = '0;
    @(negedge clk);
    resetn = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      beat_data[0] = vecs[i].b0; beat_data[1] = vecs[i].b1;
      beat_data[2] = vecs[i].b2; beat_data[3] = vecs[i].b3;
      if (vecs[i].pre_inv) model_valid = 1'b0;
      fetch(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data, vecs[i].ready_mode,
            vecs[i].inv_last, vecs[i].pre_inv, 32'd0, $sformatf("vec%0d", i));
      model_after(vecs[i].addr, vecs[i].exp_hit, vecs[i].inv_last);
    end

    // Redirect during refill: the original address is still serviced.
    beat_data[0] = 32'hf0; beat_data[1] = 32'hf1; beat_data[2] = 32'hf2; beat_data[3] = 32'hf3;
    fetch(32'hbfc0_0040, 0, 32'hf0, 0, 0, 0, 32'hbfc0_0004, "redirect");
    model_after(32'hbfc0_0040, 0, 0);
    beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33; beat_data[3] = 32'h44;
    fetch(32'hbfc0_0004, 0, 32'h22, 0, 0, 0, 32'd0, "redirect new");
    model_after(32'hbfc0_0004, 0, 0);

    // Randomized fetches against the model.
    for (int t = 0; t < 150; t++) begin
      addr = 32'hbfc0_0000 + 32'($urandom_range(0, 3) * LINE_BYTES) + 32'($urandom_range(0, LW - 1) * 4);
      pre  = ($urandom_range(0, 7) == 0);
      invl = ($urandom_range(0, 7) == 0);
      rm   = int'($urandom_range(0, 2));
      for (int w = 0; w < LW; w++) beat_data[w] = $urandom;
      if (pre) model_valid = 1'b0;
      hit = model_valid && (model_base == base_of(addr));
      exp = hit ? model_line[idx_of(addr)] : beat_data[idx_of(addr)];
      if (hit) invl = 1'b0;
      fetch(addr, hit, exp, rm, invl, pre, 32'd0, $sformatf("rand%0d", t));
      model_after(addr, hit, invl);
    end

    // Reset in the middle of a burst, then refetch the same line.
    @(negedge clk);
    ireq.valid = 1'b1;
    ireq.addr  = 32'hbfc0_0080;
    @(negedge clk);
    ireq.valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cresp.ready = 1'b1;
      cresp.last  = 1'b0;
      cresp.data  = 32'h70 + 32'(b);
      @(posedge clk);
      @(negedge clk);
    end
    cresp = '0;
    #1 check("midburst creq.valid before", 32'(creq.valid), 32'd1);
    #1 resetn = 1'b0;
    #1 check("midburst creq.valid async drop", 32'(creq.valid), 32'd0);
    check("midburst data_ok", 32'(iresp.data_ok), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    model_valid = 1'b0;
    beat_data[0] = 32'h80; beat_data[1] = 32'h81; beat_data[2] = 32'h82; beat_data[3] = 32'h83;
    fetch(32'hbfc0_0080, 0, 32'h80, 0, 0, 0, 32'd0, "after reset refetch");
    model_after(32'hbfc0_0080, 0, 0);
    fetch(32'hbfc0_008c, 1, 32'h83, 0, 0, 0, 32'd0, "after reset hit");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
